// File: rtl/ram_single_param.sv
// Parametrised single-port synchronous RAM with write-mode select, optional output register,
// read-valid strobe and clear-on-reset sweep. Define RAM_PARITY_EN to store a parity bit per word.
module ram_single_param #(
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned WRITE_MODE   = 0,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              inj_erra,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  output logic              perra,
  output logic              busya
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          MODE_WF = (WRITE_MODE == 1);
  localparam bit          MODE_NC = (WRITE_MODE == 2);

`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we_c;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  wr_word_c, rd_word_c, out_word_c;
  logic              acc_c, out_vld_c, out_perr_c;

  // State register; busya mirrors the CLEAR state one cycle ahead of the decode
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busya   <= (CLEAR_ON_RST != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busya   <= (state_d == S_CLEAR);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we_c = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

`ifdef RAM_PARITY_EN
  assign wr_word_c  = {(^dina) ^ inj_erra, dina};
  assign out_perr_c = (^out_word_c[DATA_W-1:0]) != out_word_c[DATA_W];
`else
  logic unused_inj;
  assign unused_inj = inj_erra;
  assign wr_word_c  = dina;
  assign out_perr_c = 1'b0;
`endif

  assign acc_c      = ena && (state_q == S_RUN);
  assign rd_word_c  = mem[addra];
  assign out_word_c = (wea && MODE_WF) ? wr_word_c : rd_word_c;
  // NO_CHANGE writes produce no result at all
  assign out_vld_c  = acc_c && !(wea && MODE_NC);

  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (clr_we_c)          mem[cnt_q] <= '0;
      else if (acc_c && wea) mem[addra] <= wr_word_c;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s1_vld, s1_perr;
      logic [DATA_W-1:0] s1_data;

      always_ff @(posedge clka) begin
        if (rsta) begin
          s1_vld  <= 1'b0;
          s1_data <= '0;
          s1_perr <= 1'b0;
          douta   <= '0;
          valida  <= 1'b0;
          perra   <= 1'b0;
        end else begin
          s1_vld <= out_vld_c;
          if (out_vld_c) begin
            s1_data <= out_word_c[DATA_W-1:0];
            s1_perr <= out_perr_c;
          end
          valida <= s1_vld;
          if (s1_vld) begin
            douta <= s1_data;
            perra <= s1_perr;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clka) begin
        if (rsta) begin
          douta  <= '0;
          valida <= 1'b0;
          perra  <= 1'b0;
        end else begin
          valida <= out_vld_c;
          if (out_vld_c) begin
            douta <= out_word_c[DATA_W-1:0];
            perra <= out_perr_c;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_single_param.sv
// Scoreboard bench for ram_single_param: three instances (READ_FIRST/lat1, WRITE_FIRST/lat2,
// NO_CHANGE/lat1) share one stimulus stream; a negedge monitor checks every output.
module tb_ram_single_param;

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       tb_clka = 1'b0;
  logic       rsta, ena, wea, inj_erra;
  logic [3:0] addra;
  logic [7:0] dina;
  logic [7:0] douta_w [3];
  logic       valida_w [3];
  logic       perra_w [3];
  logic       busya_w [3];

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rst_cyc = 0;
  bit         started = 0;
  bit         done = 0;
  exp_t       sb_q [3][$];
  logic [7:0] last_d [3];
  logic [7:0] mem_m [16];
  logic       par_m [16];

  always #5 tb_clka = ~tb_clka;
  always @(posedge tb_clka) cyc <= cyc + 1;

  ram_single_param #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u_rf (
    .clka(tb_clka), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .inj_erra(inj_erra), .douta(douta_w[0]), .valida(valida_w[0]), .perra(perra_w[0]),
    .busya(busya_w[0]));

  ram_single_param #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u_wf (
    .clka(tb_clka), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .inj_erra(inj_erra), .douta(douta_w[1]), .valida(valida_w[1]), .perra(perra_w[1]),
    .busya(busya_w[1]));

  ram_single_param #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(2), .OUT_REG(0), .CLEAR_ON_RST(1)) u_nc (
    .clka(tb_clka), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .inj_erra(inj_erra), .douta(douta_w[2]), .valida(valida_w[2]), .perra(perra_w[2]),
    .busya(busya_w[2]));

  function automatic logic perr_of(input logic [7:0] d, input logic p);
    logic r;
    r = ((^d) != p);
`ifndef RAM_PARITY_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 8'h00;
      par_m[i] = 1'b0;
    end
  endtask

  // One accepted access; pushes the expected result for every instance that produces one
  task automatic access(input logic we, input int a, input logic [7:0] d, input logic inj);
    exp_t e;
    @(negedge tb_clka); #1;
    ena = 1'b1; wea = we; addra = 4'(a); dina = d; inj_erra = inj;
    for (int k = 0; k < 3; k++) begin
      e.due = cyc + 1 + ((k == 1) ? 1 : 0);
      if (!we) begin
        e.d = mem_m[a]; e.p = perr_of(mem_m[a], par_m[a]);
        sb_q[k].push_back(e);
      end else if (k == 0) begin
        e.d = mem_m[a]; e.p = perr_of(mem_m[a], par_m[a]);
        sb_q[k].push_back(e);
      end else if (k == 1) begin
        e.d = d; e.p = perr_of(d, (^d) ^ inj);
        sb_q[k].push_back(e);
      end
    end
    if (we) begin
      mem_m[a] = d;
      par_m[a] = (^d) ^ inj;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge tb_clka); #1;
      ena = 1'b0; wea = 1'b0; inj_erra = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge tb_clka); #1;
    rsta = 1'b1; ena = 1'b0; wea = 1'b0;
    @(negedge tb_clka); #1;
    rsta = 1'b0;
    zero_model();
  endtask

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge tb_clka) begin
    exp_t e;
    if (rsta) begin
      started = 1;
      rst_cyc = cyc;
      for (int k = 0; k < 3; k++) begin
        for (int i = sb_q[k].size() - 1; i >= 0; i--)
          if (sb_q[k][i].due >= cyc) sb_q[k].delete(i);
        last_d[k] = 8'h00;
        check("rst_douta", k, 32'(douta_w[k]), 32'h0);
        check("rst_valida", k, 32'(valida_w[k]), 32'h0);
        check("rst_busya", k, 32'(busya_w[k]), 32'h1);
      end
    end else if (started) begin
      for (int k = 0; k < 3; k++) begin
        check("busya", k, 32'(busya_w[k]), 32'((cyc - rst_cyc) < 16));
        if (valida_w[k] === 1'b1) begin
          if (sb_q[k].size() == 0) begin
            check("unexpected_valida", k, 32'h1, 32'h0);
          end else begin
            e = sb_q[k].pop_front();
            check("latency_cyc", k, 32'(cyc), 32'(e.due));
            check("douta", k, 32'(douta_w[k]), 32'(e.d));
            check("perra", k, 32'(perra_w[k]), 32'(e.p));
            last_d[k] = e.d;
          end
        end else begin
          check("hold_douta", k, 32'(douta_w[k]), 32'(last_d[k]));
          if (sb_q[k].size() > 0 && sb_q[k][0].due <= cyc) begin
            e = sb_q[k].pop_front();
            check("missed_valida", k, 32'h0, 32'h1);
          end
        end
      end
    end
    if (done) begin
      for (int k = 0; k < 3; k++) check("queue_drained", k, 32'(sb_q[k].size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rsta = 1'b1; ena = 1'b0; wea = 1'b0; inj_erra = 1'b0; addra = 4'h0; dina = 8'h00;
    zero_model();
    for (int k = 0; k < 3; k++) last_d[k] = 8'h00;
    @(negedge tb_clka); #1;
    rsta = 1'b0;

    // Writes during the sweep must be dropped
    repeat (3) begin
      @(negedge tb_clka); #1;
      ena = 1'b1; wea = 1'b1; addra = 4'd2; dina = 8'hFF;
    end
    idle(16);

    // Everything reads back zero after the sweep
    for (int a = 0; a < 16; a++) access(1'b0, a, 8'h00, 1'b0);
    idle(3);

    // Latency and back-to-back reads
    access(1'b1, 3, 8'hA5, 1'b0);
    idle(2);
    access(1'b0, 3, 8'h00, 1'b0);
    idle(3);
    access(1'b0, 3, 8'h00, 1'b0);
    access(1'b0, 4, 8'h00, 1'b0);
    idle(3);

    // Write modes, including read-after-write on consecutive cycles
    access(1'b1, 5, 8'h11, 1'b0);
    access(1'b0, 5, 8'h00, 1'b0);
    idle(2);
    access(1'b1, 5, 8'h22, 1'b0);
    idle(2);
    access(1'b0, 5, 8'h00, 1'b0);
    idle(3);

    // Parity
    access(1'b1, 9, 8'h3C, 1'b1);
    access(1'b1, 10, 8'h3C, 1'b0);
    access(1'b0, 9, 8'h00, 1'b0);
    access(1'b0, 10, 8'h00, 1'b0);
    idle(3);

    // Reset part-way through the sweep restarts the 16-cycle window
    pulse_reset();
    idle(6);
    pulse_reset();
    idle(18);

    // Read in flight when reset hits is discarded
    access(1'b1, 3, 8'h5A, 1'b0);
    idle(2);
    access(1'b0, 3, 8'h00, 1'b0);
    pulse_reset();
    idle(18);
    access(1'b0, 3, 8'h00, 1'b0);
    idle(4);
    done = 1;
  end

endmodule
